// File: rtl/ucode_store_seq_if.sv
// Sequencer bus: start/stall/resume control, next-address feedback,
// optional control-store write port and the issued-microinstruction outputs.
interface ucode_store_seq_if #(
    parameter int AW = 6,
    parameter int DW = 26
);
    logic          start;
    logic          stall;
    logic          resume;
    logic [DW-1:0] next_uop;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] micro_op;
    logic          uop_valid;
    logic [AW-1:0] uaddr;
    logic          halted;
    logic [15:0]   uop_count;

    modport master (
        output start, stall, resume, next_uop, wr_en, wr_addr, wr_data,
        input  micro_op, uop_valid, uaddr, halted, uop_count
    );

    modport slave (
        input  start, stall, resume, next_uop, wr_en, wr_addr, wr_data,
        output micro_op, uop_valid, uaddr, halted, uop_count
    );
endinterface

// File: rtl/ucode_store_seq.sv
// Control store and micro-address register ahead of the P-test next-address stage.
// Define UCODE_WR_EN to make the control store writable in IDLE/HALT; otherwise it is a ROM.
//
//  state | meaning
//  IDLE  | waiting for start
//  ISSUE | micro_op presented to the datapath / P-test stage
//  SEQ   | P-test next address valid; fetch it
//  HALT  | halt microword issued; waiting for resume
module ucode_store_seq #(
    parameter int          AW         = 6,
    parameter int          DW         = 26,
    parameter logic [AW-1:0] START_ADDR = '0,
    parameter int          HALT_BIT   = 25,
    parameter              INIT_FILE  = "ucode.hex"
) (
    input logic             clk,
    input logic             rst_n,
    ucode_store_seq_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_SEQ   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam int DEPTH = 2 ** AW;

    state_t        state_q, state_d;
    logic [DW-1:0] micro_op_q, micro_op_d;
    logic [AW-1:0] uaddr_q, uaddr_d;
    logic [15:0]   uop_count_q, uop_count_d;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          uop_valid;

    logic [DW-1:0] cs_mem [DEPTH];

    initial begin
        for (int i = 0; i < DEPTH; i++) cs_mem[i] = '0;
    end

    assign rd_data = cs_mem[rd_addr];

`ifdef UCODE_WR_EN
    logic wr_ok;
    assign wr_ok = bus.wr_en && ((state_q == S_IDLE) || (state_q == S_HALT));

    always_ff @(posedge clk) begin
        if (wr_ok) cs_mem[bus.wr_addr] <= bus.wr_data;
    end

    logic unused_next_hi;
    assign unused_next_hi = ^bus.next_uop[DW-1:AW];
`else
    logic unused_wr_port;
    assign unused_wr_port = ^{bus.wr_en, bus.wr_addr, bus.wr_data, bus.next_uop[DW-1:AW]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            micro_op_q  <= '0;
            uaddr_q     <= '0;
            uop_count_q <= '0;
        end else begin
            state_q     <= state_d;
            micro_op_q  <= micro_op_d;
            uaddr_q     <= uaddr_d;
            uop_count_q <= uop_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        micro_op_d  = micro_op_q;
        uaddr_d     = uaddr_q;
        uop_count_d = uop_count_q;
        rd_addr     = START_ADDR;
        uop_valid   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    rd_addr    = START_ADDR;
                    micro_op_d = rd_data;
                    uaddr_d    = START_ADDR;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                uop_valid = !bus.stall;
                if (!bus.stall) begin
                    uop_count_d = uop_count_q + 16'd1;
                    state_d     = micro_op_q[HALT_BIT] ? S_HALT : S_SEQ;
                end
            end
            S_SEQ: begin
                rd_addr    = bus.next_uop[AW-1:0];
                micro_op_d = rd_data;
                uaddr_d    = bus.next_uop[AW-1:0];
                state_d    = S_ISSUE;
            end
            S_HALT: begin
                if (bus.resume) state_d = S_SEQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.micro_op  = micro_op_q;
    assign bus.uop_valid = uop_valid;
    assign bus.uaddr     = uaddr_q;
    assign bus.halted    = (state_q == S_HALT);
    assign bus.uop_count = uop_count_q;

endmodule

// File: tb/tb_ucode_store_seq.sv
// Directed bench for ucode_store_seq: fetch/sequence, stall, halt/resume,
// reset abort with store retention, and write-port behaviour.
module tb_ucode_store_seq;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    ucode_store_seq_if #(.AW(6), .DW(26)) bus ();

    ucode_store_seq #(
        .AW(6), .DW(26), .START_ADDR(6'd0), .HALT_BIT(25), .INIT_FILE("")
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [25:0] W0 = 26'h0000042;
    localparam logic [25:0] W3 = 26'h000ABC3;
    localparam logic [25:0] W5 = 26'h0000AAA;
    localparam logic [25:0] W6 = 26'h0000777;
    localparam logic [25:0] W7 = 26'h2000007;
    localparam logic [25:0] W9 = 26'h0000155;
`ifdef UCODE_WR_EN
    localparam logic [25:0] W5_AFTER = 26'h0001234;
`else
    localparam logic [25:0] W5_AFTER = W5;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.stall = 1'b0; bus.resume = 1'b0;
        bus.next_uop = '0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        #2;
        dut.cs_mem[0] = W0;
        dut.cs_mem[3] = W3;
        dut.cs_mem[5] = W5;
        dut.cs_mem[6] = W6;
        dut.cs_mem[7] = W7;
        dut.cs_mem[9] = W9;
        #1;
        check("rst micro_op",  32'(bus.micro_op), 32'h0);
        check("rst uaddr",     32'(bus.uaddr), 32'h0);
        check("rst uop_valid", 32'(bus.uop_valid), 32'h0);
        check("rst halted",    32'(bus.halted), 32'h0);
        check("rst uop_count", 32'(bus.uop_count), 32'h0);

        tick();
        rst_n = 1'b1;
        bus.start = 1'b1;
        tick();
        check("start micro_op", 32'(bus.micro_op), 32'(W0));
        check("start uaddr",    32'(bus.uaddr), 32'h0);
        check("start valid",    32'(bus.uop_valid), 32'h1);
        bus.start = 1'b0;
        tick();
        check("seq valid", 32'(bus.uop_valid), 32'h0);
        check("seq count", 32'(bus.uop_count), 32'h1);
        bus.next_uop = 26'h3;
        tick();
        check("issue3 uaddr",    32'(bus.uaddr), 32'h3);
        check("issue3 micro_op", 32'(bus.micro_op), 32'(W3));

        bus.stall = 1'b1;
        #1;
        check("stall valid", 32'(bus.uop_valid), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall micro_op", 32'(bus.micro_op), 32'(W3));
            check("stall count",    32'(bus.uop_count), 32'h1);
            check("stall valid",    32'(bus.uop_valid), 32'h0);
        end
        bus.stall = 1'b0;
        #1;
        check("unstall valid", 32'(bus.uop_valid), 32'h1);
        tick();
        check("count2", 32'(bus.uop_count), 32'h2);
        bus.next_uop = 26'h7;
        tick();
        check("issue7 uaddr",    32'(bus.uaddr), 32'h7);
        check("issue7 micro_op", 32'(bus.micro_op), 32'(W7));

        bus.stall = 1'b1;
        tick();
        check("halt-stall halted", 32'(bus.halted), 32'h0);
        check("halt-stall count",  32'(bus.uop_count), 32'h2);
        bus.stall = 1'b0;
        tick();
        check("halt halted", 32'(bus.halted), 32'h1);
        check("halt valid",  32'(bus.uop_valid), 32'h0);
        check("halt count",  32'(bus.uop_count), 32'h3);

        bus.start = 1'b1;
        bus.wr_en = 1'b1; bus.wr_addr = 6'd5; bus.wr_data = 26'h0001234;
        tick();
        check("halt ignores start", 32'(bus.halted), 32'h1);
        check("halt micro_op held", 32'(bus.micro_op), 32'(W7));
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        bus.resume = 1'b1;
        bus.next_uop = 26'h9;
        tick();
        bus.resume = 1'b0;
        check("resume halted", 32'(bus.halted), 32'h0);
        tick();
        check("resume uaddr",    32'(bus.uaddr), 32'h9);
        check("resume micro_op", 32'(bus.micro_op), 32'(W9));
        check("resume count",    32'(bus.uop_count), 32'h3);

        bus.wr_en = 1'b1; bus.wr_addr = 6'd6; bus.wr_data = 26'h0005555;
        tick();
        bus.wr_en = 1'b0;
        check("count4", 32'(bus.uop_count), 32'h4);
        bus.next_uop = 26'h5;
        tick();
        check("fetch5 micro_op", 32'(bus.micro_op), 32'(W5_AFTER));
        tick();
        check("count5", 32'(bus.uop_count), 32'h5);

        rst_n = 1'b0;
        #1;
        check("abort micro_op", 32'(bus.micro_op), 32'h0);
        check("abort uaddr",    32'(bus.uaddr), 32'h0);
        check("abort count",    32'(bus.uop_count), 32'h0);
        check("abort halted",   32'(bus.halted), 32'h0);
        tick();
        check("abort idle", 32'(bus.micro_op), 32'h0);
        rst_n = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("restart micro_op", 32'(bus.micro_op), 32'(W0));
        check("restart uaddr",    32'(bus.uaddr), 32'h0);
        tick();
        bus.next_uop = 26'h6;
        tick();
        check("fetch6 micro_op", 32'(bus.micro_op), 32'(W6));
        check("fetch6 uaddr",    32'(bus.uaddr), 32'h6);
        check("restart count",   32'(bus.uop_count), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
